ext_mem_arbiter: RTL and testbench
==================================

// Module: ext_mem_arbiter
// PURPOSE
//  Two-master Avalon-MM arbiter sharing the single-port on-chip EXTERNAL_MEM RAM
//  (64x32, byte-enabled, address registered, q unregistered => 1-cycle read latency).
//  Master 0 is the RISC-V instruction fetch port (read-only); master 1 is the data port (read/write).
//  Round-robin arbitration, pipelined reads with a return tag, optional post-reset memory clear.
// PARAMETERS
//  ADDR_W          6   word address width; RAM depth = 2**ADDR_W
//  DATA_W          32  data width
//  BE_W            4   byteenable width (DATA_W/8)
//  CLEAR_ON_RESET  0   1: after reset, write zero to every word before serving masters
// PORTS
//  clk                  in   1       system clock
//  reset_n              in   1       asynchronous, active-low reset
//  m0_address           in   ADDR_W  instruction word address
//  m0_read              in   1       instruction read request
//  m0_waitrequest       out  1       1 = request not accepted this cycle; hold inputs
//  m0_readdata          out  DATA_W  read data, valid with m0_readdatavalid
//  m0_readdatavalid     out  1       one pulse per accepted m0 read
//  m1_address           in   ADDR_W  data word address
//  m1_read              in   1       data read request
//  m1_write             in   1       data write request
//  m1_writedata         in   DATA_W  write data
//  m1_byteenable        in   BE_W    byte lanes to write
//  m1_waitrequest       out  1       as m0_waitrequest
//  m1_readdata          out  DATA_W  read data
//  m1_readdatavalid     out  1       one pulse per accepted m1 read
//  mem_address          out  ADDR_W  to RAM address
//  mem_chipselect       out  1       RAM access this cycle
//  mem_write            out  1       RAM write strobe
//  mem_writedata        out  DATA_W  to RAM writedata
//  mem_byteenable       out  BE_W    to RAM byteenable
//  mem_clken            out  1       RAM clock enable; constant 1
//  mem_readdata         in   DATA_W  RAM q (valid cycle after the read is issued)
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=CLEAR if CLEAR_ON_RESET else ARB; clr_cnt=0; last_grant=1;
//    rd_valid_q=0; rd_tag_q=0; all *readdatavalid=0. In-flight read is dropped (no valid pulse).
//  - FSM: CLEAR -> ARB when clr_cnt==2**ADDR_W-1 and that final write is issued; ARB is terminal.
//    CLEAR: mem_chipselect=1, mem_write=1, mem_address=clr_cnt, writedata=0, byteenable=all 1;
//    clr_cnt increments each cycle; both waitrequests=1 whenever that master requests.
//  - req0=m0_read; req1=m1_read|m1_write. m1_read&m1_write together => treated as write (sim assertion fires).
//  - ARB grant: only one requester -> it wins; both -> master != last_grant wins; none -> idle.
//    last_grant updates to the winner on every granted cycle; unchanged when idle.
//    First tie after reset goes to m0.
//  - mX_waitrequest = reqX & ~grantX (combinational); 0 when reqX=0. Zero-wait accept when granted.
//  - Winner's address/writedata/byteenable muxed combinationally to mem_*; mem_chipselect=grant0|grant1;
//    mem_write=grant1&m1_write. Reads drive byteenable all 1.
//  - Write: committed at the accepting clock edge; no response.
//  - Read: accepted in cycle N -> rd_valid_q=1, rd_tag_q=winner at edge; in cycle N+1
//    mX_readdatavalid=rd_valid_q&(rd_tag_q==X), mX_readdata=mem_readdata (shared bus).
//    Back-to-back reads every cycle sustained (full pipeline, no bubble).
//  - Read-after-write same address in consecutive cycles returns new data (write edge precedes read edge).
//  - No address range check: ADDR_W matches RAM; all addresses legal, no wrap handling needed.
// TESTING
//  - Reset release, CLEAR_ON_RESET=1: 64 cycles with mem_write=1, addr 0..63, data 0; m0_read held -> waitrequest=1 until ARB.
//  - m0 only reads addr 5 (RAM word 0xDEADBEEF): accepted same cycle, m0_readdatavalid=1 next cycle, data 0xDEADBEEF.
//  - m0 and m1 read continuously: grants alternate m0,m1,m0...; each master one readdatavalid per accepted read, correct tag.
//  - m1 write addr 3 data 0x11223344 be=4'b0011, then m1 read addr 3 -> upper bytes unchanged, lower 0x3344.
//  - reset_n asserted the cycle after an accepted m1 read -> no m1_readdatavalid; outputs 0; last_grant=1.
//  - m1_read&m1_write both high addr 7 -> write performed, no readdatavalid, assertion reported.

Source files
------------

// File: rtl/ext_mem_arbiter.sv
// Round-robin arbiter that lets the instruction fetch port (m0) and the data port (m1)
// share one single-port RAM, with pipelined tagged reads and an optional post-reset clear.
module ext_mem_arbiter #(
  parameter int ADDR_W         = 6,
  parameter int DATA_W         = 32,
  parameter int BE_W           = DATA_W / 8,
  parameter bit CLEAR_ON_RESET = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic [BE_W-1:0]   m1_byteenable,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  typedef enum logic {
    ST_CLEAR,
    ST_ARB
  } state_t;

  localparam logic [ADDR_W-1:0] CLR_LAST = '1;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] clr_cnt_reg, clr_cnt_next;
  logic              last_grant_reg, last_grant_next;
  logic              rd_valid_reg, rd_valid_next;
  logic              rd_tag_reg, rd_tag_next;
  logic              req0, req1;
  logic              grant0, grant1;

  assign req0 = m0_read;
  assign req1 = m1_read | m1_write;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= CLEAR_ON_RESET ? ST_CLEAR : ST_ARB;
      clr_cnt_reg    <= '0;
      last_grant_reg <= 1'b1;
      rd_valid_reg   <= 1'b0;
      rd_tag_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      clr_cnt_reg    <= clr_cnt_next;
      last_grant_reg <= last_grant_next;
      rd_valid_reg   <= rd_valid_next;
      rd_tag_reg     <= rd_tag_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    clr_cnt_next    = clr_cnt_reg;
    last_grant_next = last_grant_reg;
    rd_valid_next   = 1'b0;
    rd_tag_next     = rd_tag_reg;
    grant0          = 1'b0;
    grant1          = 1'b0;
    mem_chipselect  = 1'b0;
    mem_write       = 1'b0;
    mem_address     = m0_address;
    mem_writedata   = '0;
    mem_byteenable  = '1;

    case (state_reg)
      ST_CLEAR: begin
        mem_chipselect = 1'b1;
        mem_write      = 1'b1;
        mem_address    = clr_cnt_reg;
        clr_cnt_next   = clr_cnt_reg + 1'b1;
        if (clr_cnt_reg == CLR_LAST) begin
          state_next = ST_ARB;
        end
      end
      ST_ARB: begin
        // On a tie the master that did not win last time goes first.
        if (req0 && (!req1 || last_grant_reg)) begin
          grant0 = 1'b1;
        end else if (req1) begin
          grant1 = 1'b1;
        end
        if (grant0 || grant1) begin
          last_grant_next = grant1;
        end
        mem_chipselect = grant0 | grant1;
        if (grant1) begin
          mem_address = m1_address;
          if (m1_write) begin
            mem_write      = 1'b1;
            mem_writedata  = m1_writedata;
            mem_byteenable = m1_byteenable;
          end
        end
        // A simultaneous read+write from m1 is served as a write only.
        rd_valid_next = grant0 | (grant1 & ~m1_write);
        if (rd_valid_next) begin
          rd_tag_next = grant1;
        end
      end
      default: begin
        state_next = ST_ARB;
      end
    endcase
  end

  assign m0_waitrequest   = req0 & ~grant0;
  assign m1_waitrequest   = req1 & ~grant1;
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = rd_valid_reg & (rd_tag_reg == 1'b0);
  assign m1_readdatavalid = rd_valid_reg & (rd_tag_reg == 1'b1);
  assign mem_clken        = 1'b1;

  a_m1_rd_wr_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
    !(m1_read && m1_write))
    else $warning("ext_mem_arbiter: m1_read and m1_write both high, served as write");

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// Bench for ext_mem_arbiter: a RAM model on the mem_* port plus a round-robin/scoreboard
// reference that predicts grants, waitrequests and tagged read returns.
module tb_ext_mem_arbiter;

  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int BW    = 4;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] m0_address;
  logic          m0_read;
  logic          m0_waitrequest;
  logic [DW-1:0] m0_readdata;
  logic          m0_readdatavalid;
  logic [AW-1:0] m1_address;
  logic          m1_read;
  logic          m1_write;
  logic [DW-1:0] m1_writedata;
  logic [BW-1:0] m1_byteenable;
  logic          m1_waitrequest;
  logic [DW-1:0] m1_readdata;
  logic          m1_readdatavalid;
  logic [AW-1:0] mem_address;
  logic          mem_chipselect;
  logic          mem_write;
  logic [DW-1:0] mem_writedata;
  logic [BW-1:0] mem_byteenable;
  logic          mem_clken;
  logic [DW-1:0] mem_readdata;

  always #5 clk = ~clk;

  ext_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  // RAM: registered address, unregistered q; starts full of junk so the clear is visible.
  logic [DW-1:0] ram [DEPTH];
  logic [AW-1:0] ram_addr_q = '0;
  logic          ram_inited = 1'b0;

  always @(posedge clk) begin
    if (!ram_inited) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= $urandom | 32'h1;
      ram_inited <= 1'b1;
    end else if (mem_clken && mem_chipselect) begin
      for (int b = 0; b < BW; b++)
        if (mem_write && mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
      ram_addr_q <= mem_address;
    end
  end
  assign mem_readdata = ram[ram_addr_q];

  int            pass_cnt  = 0;
  int            total_cnt = 0;
  int            cyc       = 0;
  logic [DW-1:0] ref_mem [DEPTH];
  int            ref_last;
  int            last_win;
  bit            pend_v;
  int            pend_tag;
  logic [DW-1:0] pend_data;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] res = old;
    for (int b = 0; b < BW; b++) if (be[b]) res[b*8 +: 8] = wd[b*8 +: 8];
    return res;
  endfunction

  task automatic zero_model();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ref_last = 1;
    pend_v   = 1'b0;
  endtask

  // Release reset and watch the 64-cycle clear sweep while m0 keeps asking.
  task automatic run_clear();
    @(negedge clk);
    m0_read = 1'b1; m0_address = '0; m1_read = 1'b0; m1_write = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      check("clr_mem_write", 32'(mem_write), 32'd1);
      check("clr_mem_address", 32'(mem_address), 32'(i));
      check("clr_mem_writedata", mem_writedata, 32'd0);
      check("clr_m0_waitrequest", 32'(m0_waitrequest), 32'd1);
    end
    zero_model();
    $display("clear sweep of %0d words done", DEPTH);
  endtask

  task automatic do_cycle(input bit r0, input logic [AW-1:0] a0, input bit r1, input bit w1,
                          input logic [AW-1:0] a1, input logic [DW-1:0] wd,
                          input logic [BW-1:0] be);
    bit req [2];
    int win;
    @(negedge clk);
    m0_read = r0; m0_address = a0;
    m1_read = r1; m1_write = w1; m1_address = a1; m1_writedata = wd; m1_byteenable = be;
    #1;
    cyc++;
    req[0] = r0;
    req[1] = r1 | w1;
    win = -1;
    for (int k = 1; k <= 2; k++) begin
      int idx;
      idx = (ref_last + k) % 2;
      if (req[idx] && win < 0) win = idx;
    end

    check("m0_waitrequest", 32'(m0_waitrequest), 32'(r0 && win != 0));
    check("m1_waitrequest", 32'(m1_waitrequest), 32'((r1 || w1) && win != 1));
    check("m0_readdatavalid", 32'(m0_readdatavalid), 32'(pend_v && pend_tag == 0));
    check("m1_readdatavalid", 32'(m1_readdatavalid), 32'(pend_v && pend_tag == 1));
    if (pend_v) check((pend_tag == 0) ? "m0_readdata" : "m1_readdata",
                      (pend_tag == 0) ? m0_readdata : m1_readdata, pend_data);
    check("mem_clken", 32'(mem_clken), 32'd1);
    check("mem_chipselect", 32'(mem_chipselect), 32'(win >= 0));
    check("mem_write", 32'(mem_write), 32'(win == 1 && w1));
    if (win >= 0) check("mem_address", 32'(mem_address), 32'((win == 0) ? a0 : a1));
    if (win == 1 && w1) begin
      check("mem_writedata", mem_writedata, wd);
      check("mem_byteenable", 32'(mem_byteenable), 32'(be));
    end

    pend_v   = 1'b0;
    last_win = win;
    if (win >= 0) ref_last = win;
    if (win == 1 && w1) begin
      ref_mem[a1] = merge(ref_mem[a1], wd, be);
    end else if (win >= 0) begin
      pend_v    = 1'b1;
      pend_tag  = win;
      pend_data = ref_mem[(win == 0) ? a0 : a1];
    end
    if (win >= 0)
      $display("cyc %0d grant m%0d %s addr %0d", cyc, win, (win == 1 && w1) ? "write" : "read",
               (win == 0) ? a0 : a1);
  endtask

  initial begin
    bit            s0_r, s1_r, s1_w;
    logic [AW-1:0] s0_a, s1_a;
    logic [DW-1:0] s1_d;
    logic [BW-1:0] s1_be;

    reset_n = 1'b0;
    m0_read = 1'b0; m0_address = '0;
    m1_read = 1'b0; m1_write = 1'b0; m1_address = '0; m1_writedata = '0; m1_byteenable = '0;
    zero_model();
    last_win = -1;

    repeat (2) @(negedge clk);
    m0_read = 1'b1;
    #1;
    check("rst_m0_readdatavalid", 32'(m0_readdatavalid), 32'd0);
    check("rst_m1_readdatavalid", 32'(m1_readdatavalid), 32'd0);
    check("rst_m0_waitrequest", 32'(m0_waitrequest), 32'd1);
    run_clear();

    // Word 5 gets a known value, then m0 reads it alone.
    do_cycle(0, 0, 0, 1, 5, 32'hDEADBEEF, 4'hF);
    do_cycle(1, 5, 0, 0, 0, 0, 0);
    do_cycle(0, 0, 0, 0, 0, 0, 0);

    // Both masters reading every cycle: grants alternate, reads pipeline back to back.
    for (int i = 0; i < 6; i++) do_cycle(1, AW'(i), 1, 0, AW'(8 + i), 0, 0);
    do_cycle(0, 0, 0, 0, 0, 0, 0);

    // Partial byte write then read-back of the same word.
    do_cycle(0, 0, 0, 1, 3, 32'hAABBCCDD, 4'hF);
    do_cycle(0, 0, 0, 1, 3, 32'h11223344, 4'b0011);
    do_cycle(0, 0, 1, 0, 3, 0, 0);
    do_cycle(0, 0, 0, 0, 0, 0, 0);

    // Read and write together behave as a write.
    do_cycle(0, 0, 1, 1, 7, 32'h0BADF00D, 4'hF);
    do_cycle(0, 0, 1, 0, 7, 0, 0);
    do_cycle(0, 0, 0, 0, 0, 0, 0);

    // Reset lands while an m1 read is in flight: its return must vanish.
    do_cycle(0, 0, 1, 0, 9, 0, 0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_m1_readdatavalid", 32'(m1_readdatavalid), 32'd0);
    check("midrst_m0_readdatavalid", 32'(m0_readdatavalid), 32'd0);
    check("midrst_m1_waitrequest", 32'(m1_waitrequest), 32'd1);
    run_clear();

    // First tie after reset goes to m0.
    do_cycle(1, 1, 1, 0, 2, 0, 0);
    check("tie_after_reset_winner", 32'(last_win), 32'd0);
    do_cycle(0, 0, 0, 0, 0, 0, 0);

    // Random traffic; a stalled master holds its request as the bus protocol requires.
    s0_r = 0; s0_a = '0; s1_r = 0; s1_w = 0; s1_a = '0; s1_d = '0; s1_be = '0;
    for (int n = 0; n < 400; n++) begin
      if (!(s0_r && last_win != 0)) begin
        s0_r = 1'($urandom_range(0, 1));
        s0_a = AW'($urandom_range(0, 7));
      end
      if (!((s1_r || s1_w) && last_win != 1)) begin
        case ($urandom_range(0, 2))
          0:       begin s1_r = 0; s1_w = 0; end
          1:       begin s1_r = 1; s1_w = 0; end
          default: begin s1_r = 0; s1_w = 1; end
        endcase
        s1_a  = AW'($urandom_range(0, 7));
        s1_d  = $urandom;
        s1_be = BW'($urandom_range(0, 15));
      end
      do_cycle(s0_r, s0_a, s1_r, s1_w, s1_a, s1_d, s1_be);
    end
    do_cycle(0, 0, 0, 0, 0, 0, 0);
    do_cycle(0, 0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
